fp_rr_scheduler: RTL and testbench
==================================

# fp_rr_scheduler

Round-robin scheduler that shares one fixed-latency, fully pipelined single-precision FP datapath (adder or multiplier on the `fp::float` format) among `NUM_REQ` requesters. It accepts at most one operand pair per cycle and drives the shared unit. It tags every issued operation and routes each result back to the requester that issued it. It sits between the requester blocks and the shared FP unit, and it owns all issue ordering and result steering.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `LATENCY`, 3: FP unit latency in cycles from `fpu_valid` to a valid `fpu_result`, ≥1.
- `EXPONENT_BITS`, 8: must match `fp::EXPONENT_BITS`.
- `FRACTION_BITS`, 23: must match `fp::FRACTION_BITS`.
- `FW` is derived, not overridable: FW = 1 + `EXPONENT_BITS` + `FRACTION_BITS`, packed as `{sign, exp, frac}`.

Ports:
- `clk`, in, 1: the single clock; rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `hold`, in, 1: while high, no new grants are issued; in-flight operations drain.
- `req_valid`, in, `NUM_REQ`: request valid, one bit per requester.
- `req_a`, in, `NUM_REQ*FW`: operand A; requester i occupies bits [i*FW +: FW].
- `req_b`, in, `NUM_REQ*FW`: operand B, same packing as `req_a`.
- `req_ready`, out, `NUM_REQ`: grant, one-hot or zero; combinational from `req_valid`, the priority pointer and `hold`.
- `fpu_valid`, out, 1: issue strobe to the FP unit (registered).
- `fpu_a`, `fpu_b`, out, FW: operands to the FP unit (registered).
- `fpu_result`, in, FW: FP unit output, sampled exactly `LATENCY` cycles after the matching `fpu_valid`.
- `rsp_valid`, out, `NUM_REQ`: result strobe, one-hot or zero (registered).
- `rsp_data`, out, FW: result, valid while any `rsp_valid` bit is high (registered).
- `inflight`, out, `$clog2(LATENCY+3)`: number of accepted operations not yet returned.
- `idle`, out, 1: high when `inflight`==0.

## Operation

- **Handshake:** requester i transfers in a cycle where `req_valid[i] && req_ready[i]`.
  - A requester holds its operands stable while `req_valid` is high and not yet granted.
  - Once asserted, `req_valid` does not drop before the transfer.
- **Arbitration:** rotating priority pointer `ptr`, range 0..`NUM_REQ`-1.
  - The grant goes to the first asserted `req_valid` searching ptr, ptr+1, … modulo `NUM_REQ`.
  - After a grant to i, `ptr` becomes (i+1) mod `NUM_REQ`.
  - With no grant, `ptr` is unchanged.
  - With `hold`=1, `req_ready` is 0 and `ptr` is unchanged.
- **Issue stage:** on a transfer, the next cycle has `fpu_valid`=1 and `fpu_a`/`fpu_b` set to the granted operands. Otherwise `fpu_valid`=0 and `fpu_a`/`fpu_b` hold their previous values.
- **Tag pipeline:** a one-hot `NUM_REQ`-bit tag enters alongside `fpu_valid` and shifts through a `LATENCY`-deep register chain. An all-zero tag denotes a bubble.
- **Response stage:** in the cycle the tag reaches the end of the chain, `fpu_result` is captured into `rsp_data`. `rsp_valid` is set to that tag on the next edge.
  - There is no response backpressure; requesters accept `rsp_valid` unconditionally.
- **Inflight counter:** +1 on a transfer, −1 on any `rsp_valid`; both in the same cycle leaves it unchanged. The maximum is `LATENCY`+2; it never wraps.
- **Bit handling:** no interpretation of the float fields; all FW bits pass through unchanged in both directions.

## Timing

- **Reset values:** `req_ready`=0 while `rst_n`=0, `fpu_valid`=0, `fpu_a`=`fpu_b`=0, `rsp_valid`=0, `rsp_data`=0, `inflight`=0, `idle`=1, `ptr`=0, all tags 0.
- **Latency:** handshake at cycle T, then `fpu_valid` at T+1, `fpu_result` sampled at T+1+`LATENCY`, and `rsp_valid` at T+2+`LATENCY`.
- **Throughput:** one transfer per cycle; responses return in issue order, and back-to-back responses are allowed.
- **Reset mid-operation:** all tags are cleared and in-flight results are discarded. No `rsp_valid` is produced for pre-reset issues, even if `fpu_result` keeps toggling.
- **`hold` timing:** asserting `hold` in the same cycle as a would-be grant suppresses that grant. `hold` does not affect the tag pipeline or response stage.
- **Single requester:** a lone requester holding `req_valid` high is granted every cycle.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream with 3 operations in flight → all outputs at reset values immediately; no `rsp_valid` ever appears for those 3.
- **Single op:** bench adder model with `LATENCY`=3; requester 2 sends A=0x3FC00000 (1.5), B=0x40100000 (2.25) at cycle T → `fpu_valid` at T+1; `rsp_valid`=4'b0100 and `rsp_data`=0x40700000 (3.75) at T+5; `inflight` 1 from T+1 through T+5, 0 at T+6.
- **Fairness:** all four `req_valid` held high for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3; responses return in the same order, one per cycle.
- **Pointer skip:** `ptr`=1, `req_valid`=4'b1001 → grant 3, `ptr` becomes 0; next cycle grant 0.
- **`hold`:** `hold`=1 for 5 cycles with `req_valid`=4'b1111 and 2 ops in flight → `req_ready`=0 throughout; both responses delivered; `idle`=1 once drained; on release, the grant resumes at the unchanged `ptr`.
- **Full pipe:** continuous issue for 20 cycles → `inflight` saturates at `LATENCY`+2=5; every tag/result pairing is correct against the scoreboard.

Source files
------------

// File: rtl/fp_rr_scheduler.sv
// Round-robin front end for one shared, fixed-latency pipelined FP unit.
// It tags each issued operation and steers every result back to the requester that issued it.
module fp_rr_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned LATENCY       = 3,
  parameter int unsigned EXPONENT_BITS = 8,
  parameter int unsigned FRACTION_BITS = 23,
  localparam int unsigned FW           = 1 + EXPONENT_BITS + FRACTION_BITS,
  localparam int unsigned IW           = $clog2(LATENCY + 3)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*FW-1:0] req_a,
  input  logic [NUM_REQ*FW-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  fpu_valid,
  output logic [FW-1:0]         fpu_a,
  output logic [FW-1:0]         fpu_b,
  input  logic [FW-1:0]         fpu_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [FW-1:0]         rsp_data,
  output logic [IW-1:0]         inflight,
  output logic                  idle
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_gidx;
  logic [PW-1:0]      w_cand;
  logic [PW:0]        w_sum;
  logic [PW-1:0]      w_ptr_nxt;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic               w_rsp_any;
  logic [FW-1:0]      w_a;
  logic [FW-1:0]      w_b;

  logic               r_fpu_valid;
  logic [FW-1:0]      r_fpu_a;
  logic [FW-1:0]      r_fpu_b;
  // Stage 0 lines up with fpu_valid; stage LATENCY lines up with a valid fpu_result.
  logic [NUM_REQ-1:0] r_tag [LATENCY+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [FW-1:0]      r_rsp_data;
  logic [IW-1:0]      r_inflight;

  // Search ptr, ptr+1, ... modulo NUM_REQ; no grant while in reset or on hold.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_xfer  = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PW+1)'(NUM_REQ);
      end
      w_cand = w_sum[PW-1:0];
      if (rst_n && !hold && !w_xfer && req_valid[w_cand]) begin
        w_xfer = 1'b1;
        w_gidx = w_cand;
      end
    end
    w_grant[w_gidx] = w_xfer;
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a = req_a[i*FW +: FW];
        w_b = req_b[i*FW +: FW];
      end
    end
  end

  assign w_ptr_nxt = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
  assign w_rsp_any = |r_rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_fpu_valid <= 1'b0;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
    end else begin
      r_fpu_valid <= w_xfer;
      if (w_xfer) begin
        r_ptr   <= w_ptr_nxt;
        r_fpu_a <= w_a;
        r_fpu_b <= w_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= LATENCY; k++) begin
        r_tag[k] <= '0;
      end
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_tag[0] <= w_grant;
      for (int unsigned k = 1; k <= LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      r_rsp_valid <= r_tag[LATENCY];
      if (|r_tag[LATENCY]) begin
        r_rsp_data <= fpu_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      unique case ({w_xfer, w_rsp_any})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign fpu_valid = r_fpu_valid;
  assign fpu_a     = r_fpu_a;
  assign fpu_b     = r_fpu_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign inflight  = r_inflight;
  assign idle      = (r_inflight == '0);

endmodule

// File: tb/tb_fp_rr_scheduler.sv
// Randomised scoreboard bench for fp_rr_scheduler with a behavioural FP adder of fixed latency.
module tb_fp_rr_scheduler;

  localparam int NR = 4;
  localparam int L  = 3;
  localparam int FW = 32;
  localparam int IW = $clog2(L + 3);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hold = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*FW-1:0] req_a = '0;
  logic [NR*FW-1:0] req_b = '0;
  logic [NR-1:0]    req_ready;
  logic             fpu_valid;
  logic [FW-1:0]    fpu_a;
  logic [FW-1:0]    fpu_b;
  logic [FW-1:0]    fpu_result = '0;
  logic [NR-1:0]    rsp_valid;
  logic [FW-1:0]    rsp_data;
  logic [IW-1:0]    inflight;
  logic             idle;

  fp_rr_scheduler #(
    .NUM_REQ      (NR),
    .LATENCY      (L),
    .EXPONENT_BITS(8),
    .FRACTION_BITS(23)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .fpu_valid (fpu_valid),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_result(fpu_result),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .inflight  (inflight),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] tag;
    logic [FW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            iq[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic          pending [NR];
  logic [FW-1:0] opa [NR];
  logic [FW-1:0] opb [NR];
  int            mptr = 0;
  logic          m_fv = 1'b0;
  logic [FW-1:0] m_fa = '0;
  logic [FW-1:0] m_fb = '0;
  logic [FW-1:0] pipe [L+1];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic real s2r(input logic [31:0] a);
    logic [63:0] d;
    int          e;
    if (a[30:0] == 31'd0) return 0.0;
    e = int'(a[30:23]) + 896;
    d = {a[31], e[10:0], a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) + s2r(b));
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(100, 150));
    return r;
  endfunction

  // Behavioural shared adder: result of an issue appears L cycles later, junk otherwise.
  initial begin
    for (int k = 0; k <= L; k++) pipe[k] = $urandom;
    forever begin
      @(posedge clk);
      #1;
      for (int k = L; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = fpu_valid ? fadd(fpu_a, fpu_b) : $urandom;
      fpu_result = pipe[L];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (|rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_spurious", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_tag", 64'(rsp_valid), 64'(e.tag));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("rsp_missing", 64'(rsp_valid), 64'(e.tag));
    end
  end

  function automatic int model_grant(input logic h);
    int idx;
    if (h) return -1;
    for (int k = 0; k < NR; k++) begin
      idx = (mptr + k) % NR;
      if (pending[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic raise(input int i, input logic [FW-1:0] a, input logic [FW-1:0] b);
    if (!pending[i]) begin
      pending[i] = 1'b1;
      opa[i] = a;
      opb[i] = b;
    end
  endtask

  task automatic fill_all();
    for (int i = 0; i < NR; i++) raise(i, rand_op(), rand_op());
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic step(input logic h);
    int            g;
    int            n;
    logic [NR-1:0] er;
    hold = h;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = pending[i];
      req_a[i*FW +: FW] = pending[i] ? opa[i] : $urandom;
      req_b[i*FW +: FW] = pending[i] ? opb[i] : $urandom;
    end
    g = model_grant(h);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("fpu_valid", 64'(fpu_valid), 64'(m_fv));
    chk("fpu_a", 64'(fpu_a), 64'(m_fa));
    chk("fpu_b", 64'(fpu_b), 64'(m_fb));
    while (iq.size() > 0 && iq[0] + 2 + L < cyc) void'(iq.pop_front());
    n = iq.size();
    chk("inflight", 64'(inflight), 64'(n));
    chk("idle", 64'(idle), 64'(n == 0));
    if (g >= 0) begin
      sb.push_back('{tag: er, data: fadd(opa[g], opb[g]), due: cyc + 2 + L});
      iq.push_back(cyc);
      m_fv = 1'b1;
      m_fa = opa[g];
      m_fb = opb[g];
      pending[g] = 1'b0;
      mptr = (g + 1) % NR;
    end else begin
      m_fv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_fpu_valid", 64'(fpu_valid), 64'd0);
    chk("rst_fpu_a", 64'(fpu_a), 64'd0);
    chk("rst_fpu_b", 64'(fpu_b), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    sb.delete();
    iq.delete();
    for (int i = 0; i < NR; i++) pending[i] = 1'b0;
    mptr = 0;
    m_fv = 1'b0;
    m_fa = '0;
    m_fb = '0;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) step(1'b0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      pending[i] = 1'b0;
      opa[i] = '0;
      opb[i] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single op: requester 2, 1.5 + 2.25 = 3.75.
    raise(2, 32'h3FC0_0000, 32'h4010_0000);
    idle_cycles(8);

    // Fairness from ptr 0 with all requesters busy.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      fill_all();
      step(1'b0);
    end
    idle_cycles(L + 4);

    // Pointer skip: move ptr to 1, then 4'b1001 grants 3 then 0.
    raise(0, rand_op(), rand_op());
    step(1'b0);
    raise(0, rand_op(), rand_op());
    raise(3, rand_op(), rand_op());
    step(1'b0);
    step(1'b0);
    idle_cycles(L + 4);

    // Hold with two ops in flight and every requester waiting.
    raise(1, rand_op(), rand_op());
    raise(2, rand_op(), rand_op());
    step(1'b0);
    step(1'b0);
    fill_all();
    for (int c = 0; c < 5; c++) step(1'b1);
    for (int c = 0; c < 4; c++) step(1'b0);
    idle_cycles(L + 4);

    // Full pipe: continuous issue for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      fill_all();
      step(1'b0);
    end
    idle_cycles(L + 4);

    // Reset with three operations in flight; none of them may respond.
    for (int c = 0; c < 3; c++) begin
      fill_all();
      step(1'b0);
    end
    do_reset();
    idle_cycles(L + 6);

    // Random traffic with occasional hold.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) raise(i, rand_op(), rand_op());
      end
      step($urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < NR; i++) pending[i] = 1'b0;
    idle_cycles(L + 6);
    chk("drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
